ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester round-robin arbiter that shares one single-port synchronous RAM (write on clock edge, registered read address, one-cycle read latency) between requesters A and B. It issues at most one access per cycle and returns read data to the issuing requester one cycle after grant. It supports bounded locked bursts. It sits between two client blocks and the `Memory` instance, driving that instance's `addr`, `data_in` and `write_en` and consuming its `data_out`.

## Interface
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 8, RAM data width
- MAX_LOCK, 4, maximum consecutive grants one requester may hold via lock (≥1)

- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req_valid / b_req_valid  in  1  request present
- a_req_ready / b_req_ready  out  1  request granted this cycle (valid & ready = accepted)
- a_req_write / b_req_write  in  1  1 = write, 0 = read
- a_req_lock / b_req_lock  in  1  ask to keep grant next cycle
- a_req_addr / b_req_addr  in  ADDR_WIDTH  access address
- a_req_wdata / b_req_wdata  in  DATA_WIDTH  write data
- a_rsp_valid / b_rsp_valid  out  1  read data valid for that requester
- a_rsp_rdata / b_rsp_rdata  out  DATA_WIDTH  read data; 0 when that rsp_valid = 0
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_data_in  out  DATA_WIDTH  RAM write data
- mem_write_en  out  1  RAM write strobe
- mem_data_out  in  DATA_WIDTH  RAM read data (mem[registered addr])

## Operation
- State: last_grant (A/B), lock_owner (none/A/B), lock_cnt (0..MAX_LOCK), rsp_pend_a, rsp_pend_b.
- Grant selection (combinational, each cycle):
  - lock_owner = X, X valid, and lock_cnt < MAX_LOCK -> grant X.
  - Otherwise, only one valid -> grant it.
  - Both valid -> grant the one ≠ last_grant.
  - Neither valid -> no grant.
- Ready is asserted only for the granted requester. No grant -> both ready = 0, mem_write_en = 0, mem_addr = last driven address (held register; avoids spurious address toggling).
- Grant to X: mem_addr = X_addr, mem_data_in = X_wdata, mem_write_en = X_write.
- Lock: after a grant to X with X_req_lock = 1:
  - If lock_owner was X, lock_cnt += 1.
  - Otherwise lock_owner := X and lock_cnt := 1.
- Lock is released (lock_owner := none, lock_cnt := 0) when:
  - the granted request has lock = 0, or
  - lock_cnt reaches MAX_LOCK, or
  - the owner drops valid.
- At the MAX_LOCK cap, the other requester, if valid, wins the next cycle.
- last_grant updates on every grant.
- Read grant to X sets rsp_pend_X for one cycle -> X_rsp_valid = 1 next cycle, X_rsp_rdata = mem_data_out. Write grants produce no response.
- Responses cannot be back-pressured; requesters must accept them.
- Reset values:
  - all ready = 0, rsp_valid = 0, rsp_rdata = 0
  - mem_write_en = 0, mem_addr = 0, mem_data_in = 0
  - last_grant = B, so A wins the first tie
  - lock_owner = none, lock_cnt = 0

## Timing
- Request to grant: 0 cycles (ready is combinational from valid and state). Request inputs must be stable while valid until accepted.
- Read latency: grant in cycle N -> rsp_valid in cycle N+1. Throughput is one access per cycle total.
- Write at N then read of the same address at N+1 -> response at N+2 returns the new data.
- A read at N+1 from either requester after a write at N by the other requester also sees the new data.
- rst_n assertion mid-operation:
  - all state clears asynchronously, including pending responses (in-flight read lost; no rsp_valid after release);
  - any write strobe in the cycle of reset is suppressed.
- First grant is possible in the first cycle after rst_n deasserts.

## Test plan
- After reset: A writes 0x5A to 0x10 (cycle N), A reads 0x10 (N+1) -> a_rsp_valid = 1 at N+2 with 0x5A; b_rsp_valid stays 0.
- Both valid continuously with reads to 0x01 (A) and 0x02 (B), lock = 0 -> grants strictly alternate A, B, A, B…; responses arrive on the matching port one cycle after each grant.
- A holds lock = 1 with 6 back-to-back reads while B valid, MAX_LOCK = 4 -> A granted 4 cycles, B granted on the 5th, A resumes on the 6th.
- B writes 0xC3 to 0x20 at N while A is idle; A reads 0x20 at N+1 -> a_rsp_rdata = 0xC3 at N+2.
- rst_n pulled low the cycle after an A read grant -> a_rsp_valid never asserts; after release, the first tie is granted to A.
- Idle cycles (no valid) -> mem_write_en = 0, mem_addr unchanged from the last grant, both ready = 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B,
// with bounded lock bursts and one-cycle read responses routed back to the issuing port.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_write,
  input  logic                  a_req_lock,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_write,
  input  logic                  b_req_lock,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
  localparam logic [1:0] LOCK_NONE = 2'd0;
  localparam logic [1:0] LOCK_A    = 2'd1;
  localparam logic [1:0] LOCK_B    = 2'd2;

  logic                  last_grant_b;
  logic [1:0]            lock_owner, lock_owner_nx, grant_owner;
  logic [CNT_W-1:0]      lock_cnt, lock_cnt_nx, cnt_inc;
  logic                  rsp_pend_a, rsp_pend_b;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] wdata_hold;
  logic                  grant_a, grant_b, grant_any, grant_lock, owner_dropped;

  // Grant is suppressed while reset is asserted, which also kills any write strobe.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (lock_owner == LOCK_A && a_req_valid && lock_cnt < LOCK_MAX) begin
        grant_a = 1'b1;
      end else if (lock_owner == LOCK_B && b_req_valid && lock_cnt < LOCK_MAX) begin
        grant_b = 1'b1;
      end else if (a_req_valid && b_req_valid) begin
        grant_a = last_grant_b;
        grant_b = ~last_grant_b;
      end else begin
        grant_a = a_req_valid;
        grant_b = b_req_valid;
      end
    end
  end

  assign grant_any    = grant_a | grant_b;
  assign a_req_ready  = grant_a;
  assign b_req_ready  = grant_b;
  assign mem_write_en = (grant_a & a_req_write) | (grant_b & b_req_write);
  assign mem_addr     = grant_a ? a_req_addr  : (grant_b ? b_req_addr  : addr_hold);
  assign mem_data_in  = grant_a ? a_req_wdata : (grant_b ? b_req_wdata : wdata_hold);

  assign a_rsp_valid = rsp_pend_a;
  assign b_rsp_valid = rsp_pend_b;
  assign a_rsp_rdata = rsp_pend_a ? mem_data_out : '0;
  assign b_rsp_rdata = rsp_pend_b ? mem_data_out : '0;

  assign grant_lock    = (grant_a & a_req_lock) | (grant_b & b_req_lock);
  assign grant_owner   = grant_a ? LOCK_A : LOCK_B;
  assign owner_dropped = (lock_owner == LOCK_A && !a_req_valid) ||
                         (lock_owner == LOCK_B && !b_req_valid);

  // A burst that reaches the cap releases at once so the other side wins the next tie.
  always_comb begin
    lock_owner_nx = lock_owner;
    lock_cnt_nx   = lock_cnt;
    cnt_inc       = (lock_owner == grant_owner) ? lock_cnt + CNT_W'(1) : CNT_W'(1);
    if (grant_any) begin
      if (grant_lock && cnt_inc < LOCK_MAX) begin
        lock_owner_nx = grant_owner;
        lock_cnt_nx   = cnt_inc;
      end else begin
        lock_owner_nx = LOCK_NONE;
        lock_cnt_nx   = '0;
      end
    end else if (owner_dropped) begin
      lock_owner_nx = LOCK_NONE;
      lock_cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_b <= 1'b1;
      lock_owner   <= LOCK_NONE;
      lock_cnt     <= '0;
      rsp_pend_a   <= 1'b0;
      rsp_pend_b   <= 1'b0;
      addr_hold    <= '0;
      wdata_hold   <= '0;
    end else begin
      lock_owner <= lock_owner_nx;
      lock_cnt   <= lock_cnt_nx;
      rsp_pend_a <= grant_a & ~a_req_write;
      rsp_pend_b <= grant_b & ~b_req_write;
      if (grant_any) begin
        last_grant_b <= grant_b;
        addr_hold    <= mem_addr;
        wdata_hold   <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus randomized bench for ram_port_arbiter against a behavioural arbiter/RAM model.
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req_valid, a_req_ready, a_req_write, a_req_lock;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          a_rsp_valid;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_write, b_req_lock;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          b_rsp_valid;
  logic [DW-1:0] b_rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_write_en;
  logic [DW-1:0] mem_data_out;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_lock(a_req_lock), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_lock(b_req_lock), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out)
  );

  // Single-port synchronous RAM with registered read address
  logic [DW-1:0] ram [0:255];
  logic [AW-1:0] ram_raddr;
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_data_in;
    ram_raddr <= mem_addr;
  end
  assign mem_data_out = ram[ram_raddr];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: who was served last, who holds a lock and for how many grants
  logic [DW-1:0] shadow [0:255];
  int            m_last, m_holder, m_run, m_grant;
  logic [AW-1:0] m_addr_hold;
  logic          m_rsp_a, m_rsp_b;
  logic [DW-1:0] m_rdata_a, m_rdata_b;
  logic          obs_a, obs_b, obs_we;
  logic [AW-1:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_holder = -1; m_run = 0;
    m_addr_hold = '0;
    m_rsp_a = 1'b0; m_rsp_b = 1'b0;
    m_rdata_a = '0; m_rdata_b = '0;
  endtask

  function automatic int pick();
    if (!rst_n) return -1;
    if (m_holder == 0 && a_req_valid && m_run < ML) return 0;
    if (m_holder == 1 && b_req_valid && m_run < ML) return 1;
    if (a_req_valid && b_req_valid) return (m_last == 0) ? 1 : 0;
    if (a_req_valid) return 0;
    if (b_req_valid) return 1;
    return -1;
  endfunction

  task automatic check_cycle();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    m_grant = pick();
    ea = m_addr_hold; ed = '0; ew = 1'b0;
    if (m_grant == 0) begin ea = a_req_addr; ed = a_req_wdata; ew = a_req_write; end
    if (m_grant == 1) begin ea = b_req_addr; ed = b_req_wdata; ew = b_req_write; end
    obs_a = a_req_ready; obs_b = b_req_ready; obs_addr = mem_addr; obs_we = mem_write_en;
    chk("a_ready", 32'(a_req_ready), 32'(m_grant == 0));
    chk("b_ready", 32'(b_req_ready), 32'(m_grant == 1));
    chk("mem_we", 32'(mem_write_en), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    if (m_grant >= 0) chk("mem_data_in", 32'(mem_data_in), 32'(ed));
    chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_rsp_a));
    chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'(m_rsp_a ? m_rdata_a : 8'h00));
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_rsp_b));
    chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(m_rsp_b ? m_rdata_b : 8'h00));
  endtask

  task automatic model_edge();
    logic          w, lk;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    m_rsp_a = 1'b0; m_rsp_b = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_grant >= 0) begin
      w  = (m_grant == 0) ? a_req_write : b_req_write;
      lk = (m_grant == 0) ? a_req_lock  : b_req_lock;
      ad = (m_grant == 0) ? a_req_addr  : b_req_addr;
      wd = (m_grant == 0) ? a_req_wdata : b_req_wdata;
      m_last = m_grant;
      m_addr_hold = ad;
      if (w) shadow[ad] = wd;
      else if (m_grant == 0) begin m_rsp_a = 1'b1; m_rdata_a = shadow[ad]; end
      else begin m_rsp_b = 1'b1; m_rdata_b = shadow[ad]; end
      if (lk) begin
        m_run = (m_holder == m_grant) ? m_run + 1 : 1;
        m_holder = m_grant;
      end else begin
        m_holder = -1; m_run = 0;
      end
    end else if ((m_holder == 0 && !a_req_valid) || (m_holder == 1 && !b_req_valid)) begin
      m_holder = -1; m_run = 0;
    end
    if (m_run >= ML) begin m_holder = -1; m_run = 0; end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic w, input logic lk, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd);
    a_req_valid = v; a_req_write = w; a_req_lock = lk; a_req_addr = ad; a_req_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic w, input logic lk, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd);
    b_req_valid = v; b_req_write = w; b_req_lock = lk; b_req_addr = ad; b_req_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    for (int i = 0; i < 256; i++) begin
      ram[i] <= 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    rst_n = 1'b0;
    model_reset();
    set_a(1'b1, 1'b1, 1'b0, 8'h33, 8'hEE);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();
    chk("rst_we_suppressed", 32'(obs_we), 32'd0);
    chk("rst_no_ready", 32'({obs_a, obs_b}), 32'd0);

    // Write then read-back on A right after reset release
    rst_n = 1'b1;
    set_a(1'b1, 1'b1, 1'b0, 8'h10, 8'h5A);
    step();
    chk("t1_wr_grant", 32'({obs_a, obs_we}), 32'h3);
    set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    step();
    chk("t1_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("t1_rsp_rdata", 32'(a_rsp_rdata), 32'h5A);
    chk("t1_b_quiet", 32'(b_rsp_valid), 32'd0);

    // Alternation: last grant was A, so B leads
    set_a(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_grant", 32'({obs_a, obs_b}), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_rsp_port", 32'({a_rsp_valid, b_rsp_valid}), 32'({obs_a, obs_b}));
    end
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Locked burst capped at ML grants
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 1'b0, 1'b1, 8'(8'h40 + acc), 8'h00);
      step();
      chk("lock_seq", 32'({obs_a, obs_b}), (i == 4) ? 32'h1 : 32'h2);
      if (obs_a) acc++;
    end

    // Cross-port write-then-read coherence
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b1, 1'b1, 1'b0, 8'h20, 8'hC3);
    step();
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_a(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    step();
    chk("xport_rdata", 32'(a_rsp_rdata), 32'hC3);

    // Idle: address held, no strobe
    set_a(1'b0, 1'b0, 1'b0, 8'h77, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_addr", 32'(obs_addr), 32'h20);
      chk("idle_quiet", 32'({obs_a, obs_b, obs_we}), 32'd0);
    end

    // Reset right after a read grant drops the response
    set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    step();
    set_a(1'b1, 1'b0, 1'b0, 8'h11, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 8'h12, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_kills_rsp", 32'(a_rsp_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_tie", 32'({obs_a, obs_b}), 32'h2);

    // Randomized traffic; a request stays put until accepted
    for (int c = 0; c < 400; c++) begin
      if (!a_req_valid || obs_a)
        set_a(($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 15)), 8'($urandom));
      if (!b_req_valid || obs_b)
        set_b(($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 15)), 8'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
